// File: rtl/timer_pkg.sv
// Shared types and mm:ss arithmetic helpers for the panel countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } timer_state_e;

    localparam logic [6:0]  SEC_MAX = 7'd59;
    localparam int unsigned BCD_W   = 4;

    typedef struct packed {
        logic [6:0] mm;
        logic [6:0] ss;
    } mmss_t;

    // Add add_sec seconds with carry into minutes, saturating at max_min:59.
    function automatic mmss_t mmss_sat_add(input mmss_t t, input logic [6:0] add_sec,
                                           input logic [6:0] max_min);
        logic [7:0] ss_sum;
        logic [7:0] mm_sum;
        mmss_t      r;
        ss_sum = {1'b0, t.ss} + {1'b0, add_sec};
        if (ss_sum >= 8'd60) begin
            ss_sum = ss_sum - 8'd60;
            mm_sum = {1'b0, t.mm} + 8'd1;
        end else begin
            mm_sum = {1'b0, t.mm};
        end
        if (mm_sum > {1'b0, max_min}) begin
            r.mm = max_min;
            r.ss = SEC_MAX;
        end else begin
            r.mm = mm_sum[6:0];
            r.ss = ss_sum[6:0];
        end
        return r;
    endfunction

    // One-second decrement with borrow from minutes; 00:00 stays 00:00.
    function automatic mmss_t mmss_dec(input mmss_t t);
        mmss_t r;
        if (t.ss != 7'd0) begin
            r.mm = t.mm;
            r.ss = t.ss - 7'd1;
        end else if (t.mm != 7'd0) begin
            r.mm = t.mm - 7'd1;
            r.ss = SEC_MAX;
        end else begin
            r.mm = 7'd0;
            r.ss = 7'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_to_bcd99.sv
// Combinational 0..99 binary to two BCD digits for the seven-segment driver.
module bin_to_bcd99
    import timer_pkg::*;
(
    input  logic [6:0]       bin,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] units
);

    // Split the value into tens and units digits.
    always_comb begin
        tens  = 4'(bin / 7'd10);
        units = 4'(bin % 7'd10);
    end

endmodule

// File: rtl/countdown_timer_ctl.sv
// mm:ss countdown controller: button edge detection, IDLE/RUN/PAUSE control,
// 1 s tick-enable, +ADD_SEC, one-shot expiry pulse and BCD digit outputs.
module countdown_timer_ctl
    import timer_pkg::*;
#(
    parameter int unsigned TICK_COUNT = 100_000_000,
    parameter int unsigned MAX_MIN    = 99,
    parameter int unsigned ADD_SEC    = 30
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             add_time,
    input  logic [6:0]       min,
    input  logic [6:0]       sec,
    output logic             done,
    output logic             running,
    output logic             paused,
    output logic             finished,
    output logic [BCD_W-1:0] min_dec,
    output logic [BCD_W-1:0] min_uni,
    output logic [BCD_W-1:0] sec_dec,
    output logic [BCD_W-1:0] sec_uni
);

    localparam logic [6:0]  MAX_MIN_C   = 7'(MAX_MIN);
    localparam logic [6:0]  ADD_SEC_C   = 7'(ADD_SEC);
    localparam logic [31:0] TICK_LAST_C = 32'(TICK_COUNT - 32'd1);

    localparam int unsigned E_STOP  = 0;
    localparam int unsigned E_PAUSE = 1;
    localparam int unsigned E_START = 2;
    localparam int unsigned E_ADD   = 3;

    logic [3:0]   lvl_s;
    logic [3:0]   lvl_cur_r;
    logic [3:0]   lvl_prev_r;
    logic         armed_r;
    logic [3:0]   edge_s;

    timer_state_e state_r;
    timer_state_e state_s;
    logic [6:0]   min_r;
    logic [6:0]   min_s;
    logic [6:0]   sec_r;
    logic [6:0]   sec_s;
    logic [31:0]  tick_cnt_r;
    logic [31:0]  tick_cnt_s;
    logic         finished_r;
    logic         finished_s;

    logic [6:0]   preset_min_s;
    logic [6:0]   preset_sec_s;
    logic         tick_s;
    mmss_t        work_s;

    assign lvl_s  = {add_time, start, pause, stop};
    assign edge_s = lvl_cur_r & ~lvl_prev_r;
    assign tick_s = (tick_cnt_r == TICK_LAST_C);

    // Edge-detector history; the first sample after reset primes both stages
    // so a button already held through reset produces no edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lvl_cur_r  <= 4'b0000;
            lvl_prev_r <= 4'b0000;
            armed_r    <= 1'b0;
        end else begin
            lvl_cur_r  <= lvl_s;
            lvl_prev_r <= armed_r ? lvl_cur_r : lvl_s;
            armed_r    <= 1'b1;
        end
    end

    // Clamp the preset switches to the displayable range.
    always_comb begin
        if (min > MAX_MIN_C) begin
            preset_min_s = MAX_MIN_C;
        end else begin
            preset_min_s = min;
        end
        if (sec > SEC_MAX) begin
            preset_sec_s = SEC_MAX;
        end else begin
            preset_sec_s = sec;
        end
    end

    // Next-state, remaining-time and tick-counter decisions.
    always_comb begin
        state_s    = state_r;
        min_s      = min_r;
        sec_s      = sec_r;
        tick_cnt_s = tick_cnt_r;
        finished_s = 1'b0;
        work_s     = {min_r, sec_r};
        case (state_r)
            IDLE: begin
                min_s = preset_min_s;
                sec_s = preset_sec_s;
                if (edge_s[E_START]) begin
                    state_s    = RUN;
                    tick_cnt_s = 32'd0;
                    if ((preset_min_s == 7'd0) && (preset_sec_s == 7'd0)) begin
                        sec_s = ADD_SEC_C;
                    end else begin
                        sec_s = preset_sec_s;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (tick_s) begin
                    tick_cnt_s = 32'd0;
                end else begin
                    tick_cnt_s = tick_cnt_r + 32'd1;
                end
                if (edge_s[E_STOP]) begin
                    state_s = IDLE;
                end else begin
                    // add first, then the tick decrement sees the sum
                    if (edge_s[E_ADD] && !edge_s[E_PAUSE]) begin
                        work_s = mmss_sat_add(work_s, ADD_SEC_C, MAX_MIN_C);
                    end else begin
                        work_s = {min_r, sec_r};
                    end
                    if (tick_s) begin
                        work_s = mmss_dec(work_s);
                    end else begin
                        work_s = work_s;
                    end
                    min_s = work_s.mm;
                    sec_s = work_s.ss;
                    // reaching zero beats a coincident pause
                    if (tick_s && (work_s.mm == 7'd0) && (work_s.ss == 7'd0)) begin
                        state_s    = IDLE;
                        finished_s = 1'b1;
                    end else if (edge_s[E_PAUSE]) begin
                        state_s = PAUSE;
                    end else begin
                        state_s = RUN;
                    end
                end
            end
            PAUSE: begin
                if (edge_s[E_STOP]) begin
                    state_s = IDLE;
                end else if (edge_s[E_PAUSE] || edge_s[E_START]) begin
                    state_s = RUN;
                end else if (edge_s[E_ADD]) begin
                    work_s = mmss_sat_add(work_s, ADD_SEC_C, MAX_MIN_C);
                    min_s  = work_s.mm;
                    sec_s  = work_s.ss;
                end else begin
                    state_s = PAUSE;
                end
            end
            default: begin
                state_s    = IDLE;
                tick_cnt_s = 32'd0;
            end
        endcase
    end

    // Control state, remaining time, tick counter and expiry pulse registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            min_r      <= 7'd0;
            sec_r      <= 7'd0;
            tick_cnt_r <= 32'd0;
            finished_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            min_r      <= min_s;
            sec_r      <= sec_s;
            tick_cnt_r <= tick_cnt_s;
            finished_r <= finished_s;
        end
    end

    assign done     = (state_r == IDLE);
    assign running  = (state_r == RUN);
    assign paused   = (state_r == PAUSE);
    assign finished = finished_r;

    bin_to_bcd99 u_min_bcd (
        .bin   (min_r),
        .tens  (min_dec),
        .units (min_uni)
    );

    bin_to_bcd99 u_sec_bcd (
        .bin   (sec_r),
        .tens  (sec_dec),
        .units (sec_uni)
    );

endmodule
